// File: rtl/tone_scheduler.sv
// Note scheduler: queues (half-period, beats) notes in a small FIFO and plays each
// as a signed square wave for the speaker serializer, with rests, pause and volume.
module tone_scheduler #(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic [21:0]                   note_div,
  input  logic [3:0]                    note_beats,
  input  logic                          pause,
  input  logic [2:0]                    volume,
  output logic [15:0]                   audio_in_left,
  output logic [15:0]                   audio_in_right,
  output logic                          playing,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BEAT_CYCLES);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t state;

  logic [21:0]   div_mem   [FIFO_DEPTH];
  logic [3:0]    beats_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [LW-1:0] count_next;
  logic          push;
  logic          pop;
  logic [21:0]   head_div;
  logic [3:0]    head_beats;

  logic [21:0]   cur_div;
  logic [3:0]    beats_left;
  logic [21:0]   half_cnt;
  logic [BW-1:0] beat_cnt;
  logic          phase;
  logic [15:0]   sample;
  logic [15:0]   amp;
  logic [15:0]   neg_amp;

  assign note_ready = (count != LW'(FIFO_DEPTH));
  assign push       = note_valid && note_ready;
  assign pop        = (state == LOAD);
  assign head_div   = div_mem[rd_ptr];
  assign head_beats = beats_mem[rd_ptr];
  assign fifo_level = count;

  assign amp     = {1'b0, volume, 12'h000};
  assign neg_amp = 16'd0 - amp;

  assign audio_in_left  = sample;
  assign audio_in_right = sample;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      div_mem[wr_ptr]   <= note_div;
      beats_mem[wr_ptr] <= note_beats;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Outputs are registered from the current state, so they trail the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_div    <= '0;
      beats_left <= '0;
      half_cnt   <= '0;
      beat_cnt   <= '0;
      phase      <= 1'b0;
      sample     <= '0;
      playing    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      playing  <= (state == LOAD) || (state == PLAY);
      if ((state == PLAY) && !pause && (cur_div != 22'd0)) begin
        sample <= phase ? amp : neg_amp;
      end else begin
        sample <= '0;
      end

      case (state)
        IDLE: begin
          if (count != '0) state <= LOAD;
        end
        LOAD: begin
          cur_div    <= head_div;
          beats_left <= head_beats;
          half_cnt   <= '0;
          beat_cnt   <= '0;
          phase      <= 1'b1;
          if (head_beats == 4'd0) begin
            state <= (count_next != '0) ? LOAD : IDLE;
          end else begin
            state <= PLAY;
          end
        end
        PLAY: begin
          if (!pause) begin
            if (cur_div != 22'd0) begin
              if (half_cnt == cur_div - 22'd1) begin
                half_cnt <= '0;
                phase    <= ~phase;
              end else begin
                half_cnt <= half_cnt + 22'd1;
              end
            end
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt   <= '0;
              beats_left <= beats_left - 4'd1;
              if (beats_left == 4'd1) begin
                if (count != '0) begin
                  state <= LOAD;
                end else begin
                  state    <= IDLE;
                  underrun <= 1'b1;
                end
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed testbench for tone_scheduler with short beats (8 cycles) and a 4-deep FIFO.
module tb_tone_scheduler;

  localparam int BEAT  = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        note_valid;
  logic        note_ready;
  logic [21:0] note_div;
  logic [3:0]  note_beats;
  logic        pause;
  logic [2:0]  volume;
  logic [15:0] audio_in_left;
  logic [15:0] audio_in_right;
  logic        playing;
  logic        underrun;
  logic [2:0]  fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tone_scheduler #(.BEAT_CYCLES(BEAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .note_valid(note_valid),
    .note_ready(note_ready),
    .note_div(note_div),
    .note_beats(note_beats),
    .pause(pause),
    .volume(volume),
    .audio_in_left(audio_in_left),
    .audio_in_right(audio_in_right),
    .playing(playing),
    .underrun(underrun),
    .fifo_level(fifo_level)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [21:0] d, input logic [3:0] b);
    note_valid = v;
    note_div   = d;
    note_beats = b;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_left"}, audio_in_left, 16'h0000);
    checkOutput({tag, "_right"}, audio_in_right, 16'h0000);
    checkOutput({tag, "_playing"}, playing, 1'b0);
    checkOutput({tag, "_underrun"}, underrun, 1'b0);
    checkOutput({tag, "_level"}, fifo_level, 3'd0);
    checkOutput({tag, "_ready"}, note_ready, 1'b1);
  endtask

  // Samples seen from the first PLAY output of the pause/volume note onward.
  logic [15:0] exp_pause [14] = '{16'h7000, 16'h7000, 16'h7000, 16'h0000, 16'h0000,
                                  16'h0000, 16'h0000, 16'h0000, 16'h7000, 16'h9000,
                                  16'h9000, 16'hF000, 16'hF000, 16'h0000};

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          sent;
    logic        hs;
    int          runs[$];
    int          run;
    logic        counting;
    logic [15:0] prev;
    int          n_under;

    rst    = 1'b1;
    pause  = 1'b0;
    volume = 3'd7;
    applyStimulus(1'b0, 22'd0, 4'd0);

    // Reset and idle
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIdle("rst");
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIdle("idle");
    end

    // Single tone, with exact start latency
    applyStimulus(1'b1, 22'd3, 4'd2);
    tick();
    applyStimulus(1'b0, 22'd0, 4'd0);
    checkOutput("tone_level1", fifo_level, 3'd1);
    checkOutput("tone_play_n1", playing, 1'b0);
    tick();
    checkOutput("tone_play_n2", playing, 1'b0);
    checkOutput("tone_smp_n2", audio_in_left, 16'h0000);
    tick();
    checkOutput("tone_play_n3", playing, 1'b1);
    checkOutput("tone_smp_n3", audio_in_left, 16'h0000);
    tick();
    for (int i = 0; i < 16; i++) begin
      checkOutput("tone_left", audio_in_left, ((i / 3) % 2 == 0) ? 16'h7000 : 16'h9000);
      checkOutput("tone_right", audio_in_right, ((i / 3) % 2 == 0) ? 16'h7000 : 16'h9000);
      checkOutput("tone_underrun", underrun, (i == 15));
      checkOutput("tone_playing", playing, 1'b1);
      tick();
    end
    checkOutput("tone_end_smp", audio_in_left, 16'h0000);
    checkOutput("tone_end_play", playing, 1'b0);
    checkOutput("tone_end_under", underrun, 1'b0);
    checkOutput("tone_end_level", fifo_level, 3'd0);
    tick(3);

    // Rest, discarded note, then a period-4 tone
    applyStimulus(1'b1, 22'd0, 4'd1);
    tick();
    applyStimulus(1'b1, 22'd5, 4'd0);
    tick();
    applyStimulus(1'b1, 22'd2, 4'd1);
    tick();
    applyStimulus(1'b0, 22'd0, 4'd0);
    for (int i = 0; i < 11; i++) begin
      checkOutput("rest_playing", playing, 1'b1);
      checkOutput("rest_smp", audio_in_left, 16'h0000);
      checkOutput("rest_under", underrun, 1'b0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      checkOutput("rest_tone", audio_in_left, (i % 4 < 2) ? 16'h7000 : 16'h9000);
      checkOutput("rest_tone_under", underrun, (i == 7));
      tick();
    end
    checkOutput("rest_end_play", playing, 1'b0);
    checkOutput("rest_end_smp", audio_in_left, 16'h0000);
    tick(3);

    // Backpressure: six notes of distinct half-period held on the source
    sent     = 0;
    counting = 1'b0;
    run      = 0;
    prev     = 16'h0000;
    n_under  = 0;
    applyStimulus(1'b1, 22'd1, 4'd1);
    for (int j = 0; j < 80; j++) begin
      hs = note_valid && note_ready;
      tick();
      if (hs) sent++;
      applyStimulus(sent < 6, 22'(sent + 1), 4'd1);
      if (j == 4) begin
        checkOutput("bp_full_level", fifo_level, 3'd4);
        checkOutput("bp_full_ready", note_ready, 1'b0);
      end
      if (fifo_level == 3'd4) checkOutput("bp_ready_full", note_ready, 1'b0);
      checkOutput("bp_level_max", (fifo_level <= 3'd4), 1'b1);
      if (counting) begin
        if (audio_in_left == 16'h7000) begin
          run++;
        end else begin
          runs.push_back(run);
          counting = 1'b0;
        end
      end else if (audio_in_left == 16'h7000 && prev == 16'h0000) begin
        counting = 1'b1;
        run      = 1;
      end
      prev = audio_in_left;
      if (underrun) begin
        n_under++;
        checkOutput("bp_under_last", runs.size(), 6);
      end
    end
    checkOutput("bp_sent", sent, 6);
    checkOutput("bp_underruns", n_under, 1);
    checkOutput("bp_notes", runs.size(), 6);
    for (int i = 0; i < runs.size() && i < 6; i++) begin
      checkOutput("bp_order", runs[i], i + 1);
    end
    checkOutput("bp_end_play", playing, 1'b0);
    tick(3);

    // Pause mid-note for 5 cycles, then volume 7 -> 1
    applyStimulus(1'b1, 22'd4, 4'd1);
    tick();
    applyStimulus(1'b0, 22'd0, 4'd0);
    tick(3);
    for (int k = 0; k < 14; k++) begin
      checkOutput("pause_smp", audio_in_left, exp_pause[k]);
      checkOutput("pause_right", audio_in_right, exp_pause[k]);
      checkOutput("pause_under", underrun, (k == 12));
      checkOutput("pause_playing", playing, (k != 13));
      pause  = (k >= 2 && k <= 6);
      volume = (k >= 10) ? 3'd1 : 3'd7;
      tick();
    end
    pause  = 1'b0;
    volume = 3'd7;
    tick(3);

    // Reset in the middle of a note with two notes still queued
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 22'd3, 4'd2);
      tick();
    end
    applyStimulus(1'b0, 22'd0, 4'd0);
    tick(3);
    checkOutput("mid_playing", playing, 1'b1);
    checkOutput("mid_level", fifo_level, 3'd2);
    checkOutput("mid_smp", audio_in_left, 16'h7000);
    rst = 1'b1;
    tick();
    checkIdle("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checkIdle("post_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tone_scheduler.md
# tone_scheduler

Note scheduler that drives the 16-bit `audio_in_left`/`audio_in_right` sample inputs of the speaker serializer. It accepts notes (half-period plus duration) from a melody source through a valid/ready handshake and buffers them in a small FIFO. It plays each note as a signed square wave at a selectable volume, inserting silence for rests and when no note is queued. It runs in the same 100 MHz domain as the serializer, and its sample outputs connect directly to it.

## Interface
- `BEAT_CYCLES`, default 25_000_000: clk cycles per beat (0.25 s at 100 MHz); must be ≥ 2.
- `FIFO_DEPTH`, default 4: note FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock; the single clock of the block.
- `rst`  in  1  synchronous, active-high reset.
- `note_valid`  in  1  source presents a note.
- `note_ready`  out  1  FIFO can accept a note; equals !full.
- `note_div`  in  22  half-period in clk cycles; 0 = rest.
- `note_beats`  in  4  duration in beats; 0 = discard.
- `pause`  in  1  freezes playback while high.
- `volume`  in  3  amplitude step, 0 = silent, 7 = loudest.
- `audio_in_left`  out  16  signed sample to the serializer.
- `audio_in_right`  out  16  signed sample, always equal to left.
- `playing`  out  1  high in LOAD and PLAY.
- `underrun`  out  1  one-cycle pulse when a note ends with the FIFO empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  entries currently queued.

## Operation
- FIFO:
  - Push on `note_valid && note_ready`; pop only in LOAD.
  - Because ready is low when full, push and pop never both target a full FIFO.
  - A push and a pop in the same cycle leave the level unchanged.
  - Notes are played strictly in arrival order.
- FSM states are IDLE, LOAD and PLAY.
- IDLE: sample is 0 and `playing` is 0. Go to LOAD when `fifo_level` != 0.
- LOAD (1 cycle):
  - Pop the head into `cur_div`/`beats_left`.
  - Clear the half-period counter and the beat counter; set `phase` = 1.
  - If the popped `note_beats` is 0, discard the note: go to LOAD if the FIFO is still non-empty, else IDLE. No underrun pulse.
  - Otherwise go to PLAY.
- PLAY, on each cycle with `pause` = 0:
  - Half-period counter increments. When it reaches `cur_div`-1, it wraps to 0 and `phase` toggles. If `cur_div` = 0, phase is ignored.
  - Beat counter increments. When it reaches `BEAT_CYCLES`-1, it wraps and `beats_left` decrements.
  - On a wrap with `beats_left` = 1, the note ends: go to LOAD if the FIFO is non-empty; else go to IDLE and pulse `underrun`.
- Pause: with `pause` = 1 in PLAY, all counters and `phase` hold and the sample is forced to 0. Pause has no effect in IDLE or LOAD.
- Amplitude and sample:
  - amp = `volume` × 4096 (0x0000 to 0x7000).
  - Sample is +amp when `phase` = 1 and −amp (two's complement) when `phase` = 0.
  - Sample is 0 for a rest, while paused, in IDLE and in LOAD.
  - `volume` is sampled every cycle; a change takes effect on the next sample.
- Reset:
  - Clears the FIFO and all counters, and forces IDLE.
  - Reset values: all outputs 0 except `note_ready` = 1.
  - Reset in the middle of a note aborts it; no underrun pulse is generated.

## Timing
- `audio_in_*`, `playing`, `underrun` and `fifo_level` are registered and reflect the state of the previous cycle.
- Note start latency: with the FSM in IDLE, a handshake in cycle N gives LOAD in N+2, the first PLAY cycle in N+3, and the first nonzero sample at the outputs in N+4.
- Note length: each note with beats > 0 occupies 1 LOAD cycle plus exactly `note_beats` × `BEAT_CYCLES` unpaused PLAY cycles.
- Back-to-back notes: no IDLE gap between consecutive queued notes; the only silence between them is the one-cycle zero sample in LOAD.
- Square wave: a tone has period 2 × `note_div` cycles. The high half comes first. The final half-period is truncated at the note end.

## Test plan
- Reset, with `BEAT_CYCLES`=8 and `FIFO_DEPTH`=4: assert `rst` for 3 cycles, then hold idle. Expect samples 0, `note_ready`=1, `fifo_level`=0, `playing`=0, and no `underrun`.
- Single tone: div=3, beats=2, volume=7. Expect samples 0x7000×3, 0x9000×3, repeating for 16 PLAY cycles. Then the sample returns to 0, `underrun` is high for exactly 1 cycle and `playing` falls.
- Backpressure: hold `note_valid` with 6 distinct notes (beats=1). Expect `note_ready` low whenever `fifo_level`=4, all 6 notes played in order, and only one underrun, after the last note.
- Rest and discard: queue div=0/beats=1, then div=5/beats=0, then div=2/beats=1. Expect 8 cycles of zero with `playing`=1, the beats=0 note skipped in one LOAD cycle, then a ±0x7000 tone with period 4 for 8 cycles.
- Pause and volume: on a div=4, beats=1 note, raise `pause` for 5 cycles in mid-note. Expect the sample held at 0, the note extended by exactly 5 cycles, and phase resuming where it left off. Changing `volume` 7→1 gives ±0x1000 from the next sample.
- Reset mid-note: assert `rst` during PLAY with 2 notes queued. Expect outputs 0 on the next cycle, `fifo_level`=0, no underrun, and no stale note played after reset.
